ibex_mem_arbiter: RTL and testbench

IBEX_MEM_ARBITER -- requirements
Module: ibex_mem_arbiter

---
 rtl/ibex_pkg.sv | 7 +
 rtl/ibex_mem_owner_fifo.sv | 42 ++++
 rtl/ibex_mem_arbiter.sv | 90 +++++++++
 tb/tb_ibex_mem_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types for the instruction/data memory arbiter
package ibex_pkg;
  typedef enum logic {
    MEM_OWNER_INSTR = 1'b0,
    MEM_OWNER_DATA  = 1'b1
  } mem_owner_e;
endpackage

// File: rtl/ibex_mem_owner_fifo.sv
// ibex_mem_owner_fifo: in-order record of which requester owns each outstanding bus transaction
module ibex_mem_owner_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned CW   = $clog2(Depth + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push,
  input  mem_owner_e    wdata,
  input  logic          pop,
  output mem_owner_e    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int unsigned PW = $clog2(Depth);
  localparam logic [PW-1:0] Last = PW'(Depth - 1);
  mem_owner_e mem_q [Depth];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic do_push, do_pop;
  assign full    = count == CW'(Depth);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q == Last ? '0 : wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q == Last ? '0 : rd_ptr_q + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter: shares one memory port between instruction fetch and LSU with starvation guard
module ibex_mem_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned StarveLimit    = 7
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic        instr_err_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic        data_err_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic        mem_err_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);
  localparam int unsigned SW = $clog2(StarveLimit + 1);
  localparam int unsigned CW = $clog2(MaxOutstanding + 1);
  localparam logic [SW-1:0] StarveMax = SW'(StarveLimit);
  mem_owner_e owner, lock_owner_q, head;
  logic lock_q, owner_req, is_data, gnt, pop, full, empty;
  logic [SW-1:0] starve_cnt_q;
  logic [CW-1:0] count;
  assign owner = lock_q ? lock_owner_q :
                 (instr_req_i && (!data_req_i || starve_cnt_q == StarveMax)) ? MEM_OWNER_INSTR : MEM_OWNER_DATA;
  assign is_data     = owner == MEM_OWNER_DATA;
  assign owner_req   = is_data ? data_req_i : instr_req_i;
  assign mem_req_o   = rst_ni & owner_req & ~full;
  assign gnt         = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = gnt & ~is_data;
  assign data_gnt_o  = gnt & is_data;
  assign mem_we_o    = is_data & data_we_i;
  assign mem_be_o    = is_data ? data_be_i : 4'hF;
  assign mem_addr_o  = is_data ? data_addr_i : instr_addr_i;
  assign mem_wdata_o = is_data ? data_wdata_i : '0;
  assign pop            = mem_rvalid_i & ~empty;
  assign instr_rvalid_o = pop & (head == MEM_OWNER_INSTR);
  assign data_rvalid_o  = pop & (head == MEM_OWNER_DATA);
  assign instr_err_o    = instr_rvalid_o & mem_err_i;
  assign data_err_o     = data_rvalid_o & mem_err_i;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign busy_o         = (count != '0) | mem_req_o;
  ibex_mem_owner_fifo #(.Depth(MaxOutstanding)) u_owner_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (gnt),
    .wdata (owner),
    .pop   (mem_rvalid_i),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q       <= 1'b0;
      lock_owner_q <= MEM_OWNER_INSTR;
      starve_cnt_q <= '0;
    end else begin
      lock_q       <= mem_req_o & ~mem_gnt_i;
      lock_owner_q <= owner;
      starve_cnt_q <= (!instr_req_i || instr_gnt_o) ? '0 :
                      starve_cnt_q == StarveMax ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
  end
  assert property (@(posedge clk_i) disable iff (!rst_ni) mem_rvalid_i |-> !empty)
    else $warning("mem_rvalid_i with no outstanding request");
  assert property (@(posedge clk_i) disable iff (!rst_ni) lock_q |-> owner_req)
    else $warning("request dropped before grant");
endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// tb_ibex_mem_arbiter: directed scenarios with a response-routing scoreboard
module tb_ibex_mem_arbiter;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic instr_req_i = 1'b0, data_req_i = 1'b0, data_we_i = 1'b0;
  logic [31:0] instr_addr_i = '0, data_addr_i = '0, data_wdata_i = '0, mem_rdata_i = '0;
  logic [3:0] data_be_i = '0;
  logic mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_err_i = 1'b0;
  logic instr_gnt_o, instr_rvalid_o, instr_err_o, data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] instr_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o;
  logic mem_req_o, mem_we_o, busy_o;
  logic [3:0] mem_be_o;
  int total = 0, bad = 0;
  logic [63:0] exp_q [$];
  logic [63:0] sb_e;
  ibex_mem_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_err_o(instr_err_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_err_o(data_err_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk_i);
    #1;
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
  endtask
  task automatic rsp(input logic is_data, input logic err, input logic [31:0] rdata);
    mem_rvalid_i = 1'b1;
    mem_err_i    = err;
    mem_rdata_i  = rdata;
    exp_q.push_back({28'b0, !is_data, is_data, err & !is_data, err & is_data, rdata});
  endtask
  always @(negedge clk_i) begin
    if (rst_ni && (instr_rvalid_o || data_rvalid_o)) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", {62'b0, instr_rvalid_o, data_rvalid_o}, 64'b0);
      else begin
        sb_e = exp_q.pop_front();
        chk("rsp_route", {28'b0, instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o, instr_rdata_o}, sb_e);
        chk("rsp_bcast", {32'b0, data_rdata_o}, {32'b0, sb_e[31:0]});
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_err_i = 1'b1;
    #2;
    chk("rst_req", mem_req_o, 0);
    chk("rst_gnt", {instr_gnt_o, data_gnt_o}, 0);
    chk("rst_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
    chk("rst_err", {instr_err_o, data_err_o}, 0);
    chk("rst_busy", busy_o, 0);
    cyc(); cyc();
    instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0; rst_ni = 1'b1;
    cyc();
    // same-cycle data write and instr fetch
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hC; data_addr_i = 32'h1000;
    data_wdata_i = 32'hDEADBEEF; instr_req_i = 1'b1; instr_addr_i = 32'h80; mem_gnt_i = 1'b1;
    #1;
    chk("t1_addr", mem_addr_o, 32'h1000);
    chk("t1_wr", {mem_req_o, mem_we_o, mem_be_o}, {1'b1, 1'b1, 4'hC});
    chk("t1_wdata", mem_wdata_o, 32'hDEADBEEF);
    chk("t1_gnt", {instr_gnt_o, data_gnt_o}, 2'b01);
    cyc();
    data_req_i = 1'b0;
    #1;
    chk("t1_iaddr", mem_addr_o, 32'h80);
    chk("t1_iattr", {mem_req_o, mem_we_o, mem_be_o}, {1'b1, 1'b0, 4'hF});
    chk("t1_iwdata", mem_wdata_o, 0);
    chk("t1_ignt", {instr_gnt_o, data_gnt_o}, 2'b10);
    cyc();
    instr_req_i = 1'b0; rsp(1'b1, 1'b0, 32'h1111_1111);
    #1;
    chk("t1_busy", busy_o, 1);
    cyc();
    rsp(1'b0, 1'b0, 32'h2222_2222);
    cyc();
    #1;
    chk("t1_idle", busy_o, 0);
    // starvation: instr waits behind continuous data traffic
    data_we_i = 1'b0; data_addr_i = 32'h2000; instr_addr_i = 32'h84;
    instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) rsp(c - 1 != 8, 1'b0, 32'hA000_0000 + 32'(c));
      #1;
      chk($sformatf("t2_gnt%0d", c), {instr_gnt_o, data_gnt_o}, c == 8 ? 2'b10 : 2'b01);
      cyc();
    end
    instr_req_i = 1'b0; data_req_i = 1'b0; rsp(1'b1, 1'b0, 32'hA000_000A);
    cyc();
    #1;
    chk("t2_idle", busy_o, 0);
    // locked instr owner holds the port while data arrives
    instr_req_i = 1'b1; instr_addr_i = 32'h200; mem_gnt_i = 1'b0; data_addr_i = 32'h3000;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) data_req_i = 1'b1;
      if (c == 4) mem_gnt_i = 1'b1;
      #1;
      chk($sformatf("t3_addr%0d", c), mem_addr_o, 32'h200);
      chk($sformatf("t3_gnt%0d", c), {mem_req_o, instr_gnt_o, data_gnt_o}, c == 4 ? 3'b110 : 3'b100);
      cyc();
    end
    instr_req_i = 1'b0; rsp(1'b0, 1'b0, 32'h3333_3333);
    #1;
    chk("t3_daddr", mem_addr_o, 32'h3000);
    chk("t3_dgnt", {instr_gnt_o, data_gnt_o}, 2'b01);
    cyc();
    data_req_i = 1'b0; rsp(1'b1, 1'b0, 32'h4444_4444);
    cyc();
    // outstanding limit
    instr_req_i = 1'b1; instr_addr_i = 32'h300; mem_gnt_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("t4_g%0d", c), {mem_req_o, instr_gnt_o}, 2'b11);
      cyc();
    end
    #1;
    chk("t4_full", {mem_req_o, instr_gnt_o, busy_o}, 3'b001);
    cyc();
    rsp(1'b0, 1'b0, 32'h5000_0001);
    #1;
    chk("t4_nobypass", mem_req_o, 0);
    cyc();
    #1;
    chk("t4_resume", {mem_req_o, instr_gnt_o}, 2'b11);
    cyc();
    instr_req_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rsp(1'b0, 1'b0, 32'h5000_0002 + 32'(k));
      cyc();
    end
    #1;
    chk("t4_drained", busy_o, 0);
    // interleaved I, D, I with an error on the data response
    instr_req_i = 1'b1; instr_addr_i = 32'h400;
    #1;
    chk("t5_g1", {instr_gnt_o, data_gnt_o}, 2'b10);
    cyc();
    instr_req_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h4000;
    #1;
    chk("t5_g2", {instr_gnt_o, data_gnt_o}, 2'b01);
    cyc();
    data_req_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'h404;
    #1;
    chk("t5_g3", {instr_gnt_o, data_gnt_o}, 2'b10);
    cyc();
    instr_req_i = 1'b0; rsp(1'b0, 1'b0, 32'h6000_0000);
    cyc();
    rsp(1'b1, 1'b1, 32'h6000_0001);
    #1;
    chk("t5_derr", {data_rvalid_o, data_err_o, instr_err_o}, 3'b110);
    cyc();
    rsp(1'b0, 1'b0, 32'h6000_0002);
    cyc();
    // reset with responses in flight
    instr_req_i = 1'b1; instr_addr_i = 32'h500; mem_gnt_i = 1'b1;
    cyc(); cyc();
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_out", {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o,
                       instr_err_o, data_err_o, busy_o}, 8'b0);
    cyc();
    instr_req_i = 1'b0; mem_gnt_i = 1'b0; rst_ni = 1'b1;
    cyc();
    mem_rvalid_i = 1'b1; mem_err_i = 1'b1; mem_rdata_i = 32'hBAD0_0000;
    #1;
    chk("t6_late", {instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o}, 4'b0);
    chk("t6_late_busy", busy_o, 0);
    cyc();
    instr_req_i = 1'b1; instr_addr_i = 32'h600; mem_gnt_i = 1'b1;
    #1;
    chk("t6_fresh", {mem_req_o, instr_gnt_o}, 2'b11);
    cyc();
    instr_req_i = 1'b0; rsp(1'b0, 1'b0, 32'h7000_0000);
    cyc();
    #1;
    chk("t6_idle", busy_o, 0);
    chk("sb_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
